// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - Philips I2S transmitter with double-buffered stereo frame
// Optional feature macro: I2S_TX_MUTE_ON_UNDERRUN_EN
//   defined   : an underrun frame transmits zeros on both channels
//   undefined : an underrun frame repeats the last played left/right pair
// Ports:
//   clk, rstn                     system clock, asynchronous active-low reset
//   enable                        run request, acted on at frame boundaries
//   read_en/read_data/read_valid  show-ahead FIFO pop interface (left, then right)
//   i2s_bclk/i2s_lrck/i2s_sdata   serial outputs to the DAC
//   underrun                      one-cycle pulse per frame played without a staged pair
//   running                       serial engine active
module i2s_tx #(
  parameter int CLK_DIV = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  output logic        read_en,
  input  logic [15:0] read_data,
  input  logic        read_valid,
  output logic        i2s_bclk,
  output logic        i2s_lrck,
  output logic        i2s_sdata,
  output logic        underrun,
  output logic        running
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [1:0] FETCH_L = 2'd0;
  localparam logic [1:0] FETCH_R = 2'd1;
  localparam logic [1:0] READY   = 2'd2;

`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
  localparam bit MUTE_ON_UNDERRUN = 1'b1;
`else
  localparam bit MUTE_ON_UNDERRUN = 1'b0;
`endif

  logic [1:0]       fsm;
  logic [15:0]      stage_l, stage_r;
  logic [15:0]      play_l, play_r;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       bit_cnt;
  logic             pop_d;

  logic             pop, tick, fall, boundary, frame_start, consume, under;
  logic [5:0]       nb;
  logic [15:0]      next_l, next_r;
  logic             sbit;

  // Pop is combinational so the word is taken in the same cycle it is
  // offered; pop_d spaces pops at least two cycles apart. Gating with rstn
  // keeps read_en low for the whole time reset is held.
  always_comb begin
    pop = rstn && read_valid && !pop_d && (fsm == FETCH_L || fsm == FETCH_R);
  end
  assign read_en = pop;

  always_comb begin
    tick        = running && (div_cnt == DIV_LAST);
    fall        = tick && i2s_bclk;
    boundary    = fall && (bit_cnt == 6'd63);
    frame_start = boundary && enable;
    consume     = frame_start && (fsm == READY);
    under       = frame_start && (fsm != READY);
    nb          = bit_cnt + 6'd1;

    next_l = play_l;
    next_r = play_r;
    if (consume) begin
      next_l = stage_l;
      next_r = stage_r;
    end else if (under && MUTE_ON_UNDERRUN) begin
      next_l = 16'h0000;
      next_r = 16'h0000;
    end

    // Slots 16..31 and 48..63 are padding; within a data slot the low four
    // bits of the position count down from the MSB.
    if (nb[4])
      sbit = 1'b0;
    else if (nb[5])
      sbit = next_r[~nb[3:0]];
    else
      sbit = next_l[~nb[3:0]];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsm       <= FETCH_L;
      stage_l   <= 16'h0000;
      stage_r   <= 16'h0000;
      play_l    <= 16'h0000;
      play_r    <= 16'h0000;
      div_cnt   <= '0;
      bit_cnt   <= 6'd63;
      pop_d     <= 1'b0;
      i2s_bclk  <= 1'b0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      underrun  <= 1'b0;
      running   <= 1'b0;
    end else begin
      pop_d    <= pop;
      underrun <= under;
      play_l   <= next_l;
      play_r   <= next_r;

      // A pop coinciding with an underrun boundary still lands in the stage.
      case (fsm)
        FETCH_L: if (pop) begin
          stage_l <= read_data;
          fsm     <= FETCH_R;
        end
        FETCH_R: if (pop) begin
          stage_r <= read_data;
          fsm     <= READY;
        end
        READY:   if (consume) fsm <= FETCH_L;
        default: fsm <= FETCH_L;
      endcase

      if (!running) begin
        if (enable && fsm == READY) begin
          running  <= 1'b1;
          div_cnt  <= '0;
          bit_cnt  <= 6'd63;
          i2s_bclk <= 1'b0;
        end
      end else if (tick) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
        if (fall) begin
          if (boundary && !enable) begin
            // Stop leaves the staged pair untouched for the next start.
            running   <= 1'b0;
            i2s_sdata <= 1'b0;
            i2s_lrck  <= 1'b0;
          end else begin
            bit_cnt   <= nb;
            i2s_sdata <= sbit;
            if (nb == 6'd31)
              i2s_lrck <= 1'b1;
            else if (nb == 6'd63)
              i2s_lrck <= 1'b0;
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule
